pcie_ltssm_ctrl: RTL and testbench

Simplified link training and status state machine that sequences the PCIe physical layer from receiver detect to L0. It sits beside `pcie_phys_top` and drives the per-lane enable mask, the ordered-set type to transmit and the encoder selection (8b/10b or 128b/130b). It also gates MAC data flow until the link is up. Counts are in `clk_i` cycles and are shortened for simulation.

---
 rtl/pcie_ltssm_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_pcie_ltssm_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_ltssm_ctrl.sv
// ---------------------------------------------------------------------------
// pcie_ltssm_ctrl
// Simplified link training and status state machine. Sequences the PHY from
// receiver detect through polling to L0, selects the ordered set to transmit,
// latches the detected-lane mask, picks 8b/10b or 128b/130b encoding and
// gates MAC data flow until the link is up.
//
// Ports
//   clk_i                        clock
//   rst_i                        asynchronous, active-high reset
//   electrical_sub_load_detect_i per-lane receiver-present flags
//   rx_ts1_i / rx_ts2_i          one-cycle pulses: TS1 / TS2 seen on all lanes
//   rx_gen3_capable_i            partner advertises 8 GT/s (valid with rx_ts2_i)
//   rx_elec_idle_i               receiver electrical idle
//   cfg_gen3_en_i                local permission to use 128b/130b
//   tx_os_done_i                 one-cycle pulse: one ordered set transmitted
//   tx_os_type_o                 0 = none, 1 = TS1, 2 = TS2
//   lane_active_o                latched detected-lane mask
//   en8b10b_o / en128b130b_o     encoder select, exactly one high
//   link_up_o / mac_tx_enable_o  high in L0
//   state_o                      current state code (debug)
//
// State table
//   state          | meaning
//   DETECT_QUIET   | 0: dwell QUIET_CYCLES, transmit nothing
//   DETECT_ACTIVE  | 1: one cycle, sample receiver-present flags into lane mask
//   POLLING_ACTIVE | 2: send TS1, count tx sets and rx TS1/TS2, time out
//   POLLING_CONFIG | 3: send TS2, count tx sets and rx TS2, capture gen3 cap.
//   L0             | 4: link up, leave on a run of electrical-idle cycles
//   5..7           | illegal, recover to DETECT_QUIET
// ---------------------------------------------------------------------------
module pcie_ltssm_ctrl #(
  parameter int NUM_LANES        = 4,
  parameter int QUIET_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES   = 1024,
  parameter int TX_TS_MIN        = 16,
  parameter int RX_TS_MIN        = 8,
  parameter int IDLE_EXIT_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_LANES-1:0] electrical_sub_load_detect_i,
  input  logic                 rx_ts1_i,
  input  logic                 rx_ts2_i,
  input  logic                 rx_gen3_capable_i,
  input  logic                 rx_elec_idle_i,
  input  logic                 cfg_gen3_en_i,
  input  logic                 tx_os_done_i,
  output logic [1:0]           tx_os_type_o,
  output logic [NUM_LANES-1:0] lane_active_o,
  output logic                 en8b10b_o,
  output logic                 en128b130b_o,
  output logic                 link_up_o,
  output logic                 mac_tx_enable_o,
  output logic [2:0]           state_o
);

  localparam int DWELL_W = $clog2(QUIET_CYCLES + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TX_W    = $clog2(TX_TS_MIN + 1);
  localparam int RX_W    = $clog2(RX_TS_MIN + 1);
  localparam int IDLE_W  = $clog2(IDLE_EXIT_CYCLES + 1);

  localparam logic [DWELL_W-1:0] QUIET_LAST = DWELL_W'(QUIET_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TX_W-1:0]    TX_MIN     = TX_W'(TX_TS_MIN);
  localparam logic [RX_W-1:0]    RX_MIN     = RX_W'(RX_TS_MIN);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_EXIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_DETECT_QUIET   = 3'd0,
    ST_DETECT_ACTIVE  = 3'd1,
    ST_POLLING_ACTIVE = 3'd2,
    ST_POLLING_CONFIG = 3'd3,
    ST_L0             = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [TX_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic [RX_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic                 gen3_cap_q, gen3_cap_d;
  logic                 gen3_q, gen3_d;
  logic [NUM_LANES-1:0] lane_q, lane_d;

  logic [1:0]           tx_os_type_q, tx_os_type_d;
  logic                 link_up_q, link_up_d;
  logic                 en128_q, en128_d;

  logic                 tx_sat, rx_sat;

  assign tx_sat = (tx_cnt_q >= TX_MIN);
  assign rx_sat = (rx_cnt_q >= RX_MIN);

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    tmo_d      = tmo_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    idle_d     = idle_q;
    gen3_cap_d = gen3_cap_q;
    gen3_d     = gen3_q;
    lane_d     = lane_q;

    case (state_q)
      ST_DETECT_QUIET: begin
        dwell_d = dwell_q + DWELL_W'(1);
        if (dwell_q == QUIET_LAST) begin
          state_d = ST_DETECT_ACTIVE;
        end
      end

      ST_DETECT_ACTIVE: begin
        lane_d  = electrical_sub_load_detect_i;
        state_d = (|electrical_sub_load_detect_i) ? ST_POLLING_ACTIVE : ST_DETECT_QUIET;
      end

      ST_POLLING_ACTIVE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (tx_os_done_i && !tx_sat) begin
          tx_cnt_d = tx_cnt_q + TX_W'(1);
        end
        if ((rx_ts1_i || rx_ts2_i) && !rx_sat) begin
          rx_cnt_d = rx_cnt_q + RX_W'(1);
        end
        // completion is tested first so it beats a coincident timeout
        if (tx_sat && rx_sat) begin
          state_d = ST_POLLING_CONFIG;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_DETECT_QUIET;
        end
      end

      ST_POLLING_CONFIG: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (tx_os_done_i && !tx_sat) begin
          tx_cnt_d = tx_cnt_q + TX_W'(1);
        end
        if (rx_ts2_i) begin
          gen3_cap_d = rx_gen3_capable_i;
          if (!rx_sat) begin
            rx_cnt_d = rx_cnt_q + RX_W'(1);
          end
        end
        if (tx_sat && rx_sat) begin
          state_d = ST_L0;
          gen3_d  = gen3_cap_q & cfg_gen3_en_i;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_DETECT_QUIET;
        end
      end

      ST_L0: begin
        if (rx_elec_idle_i) begin
          if (idle_q == IDLE_LAST) begin
            state_d = ST_DETECT_QUIET;
            gen3_d  = 1'b0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end else begin
          idle_d = '0;
        end
      end

      default: begin
        state_d = ST_DETECT_QUIET;
        gen3_d  = 1'b0;
      end
    endcase

    if (state_d != state_q) begin
      dwell_d  = '0;
      tmo_d    = '0;
      tx_cnt_d = '0;
      rx_cnt_d = '0;
      idle_d   = '0;
    end

    // each pass through POLLING_CONFIG starts with no capability captured
    if ((state_d == ST_POLLING_CONFIG) && (state_q != ST_POLLING_CONFIG)) begin
      gen3_cap_d = 1'b0;
    end
  end

  // output registers are loaded from the next state so they move with it
  always_comb begin
    tx_os_type_d = 2'd0;
    link_up_d    = 1'b0;
    en128_d      = 1'b0;
    case (state_d)
      ST_POLLING_ACTIVE: tx_os_type_d = 2'd1;
      ST_POLLING_CONFIG: tx_os_type_d = 2'd2;
      ST_L0: begin
        link_up_d = 1'b1;
        en128_d   = gen3_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_DETECT_QUIET;
      dwell_q      <= '0;
      tmo_q        <= '0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      idle_q       <= '0;
      gen3_cap_q   <= 1'b0;
      gen3_q       <= 1'b0;
      lane_q       <= '0;
      tx_os_type_q <= 2'd0;
      link_up_q    <= 1'b0;
      en128_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      tmo_q        <= tmo_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      idle_q       <= idle_d;
      gen3_cap_q   <= gen3_cap_d;
      gen3_q       <= gen3_d;
      lane_q       <= lane_d;
      tx_os_type_q <= tx_os_type_d;
      link_up_q    <= link_up_d;
      en128_q      <= en128_d;
    end
  end

  assign state_o         = state_q;
  assign tx_os_type_o    = tx_os_type_q;
  assign lane_active_o   = lane_q;
  assign link_up_o       = link_up_q;
  assign mac_tx_enable_o = link_up_q;
  assign en128b130b_o    = en128_q;
  // derived from one flop so the two selects can never both be high
  assign en8b10b_o       = ~en128_q;

endmodule

// File: tb/tb_pcie_ltssm_ctrl.sv
module tb_pcie_ltssm_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] load_det;
  logic       rx_ts1, rx_ts2, rx_gen3_cap, rx_eidle, cfg_gen3, tx_done;
  logic [1:0] tx_os_type;
  logic [3:0] lane_active;
  logic       en8, en128, link_up, mac_en;
  logic [2:0] state;

  pcie_ltssm_ctrl dut (
    .clk_i                        (clk_i),
    .rst_i                        (rst_i),
    .electrical_sub_load_detect_i (load_det),
    .rx_ts1_i                     (rx_ts1),
    .rx_ts2_i                     (rx_ts2),
    .rx_gen3_capable_i            (rx_gen3_cap),
    .rx_elec_idle_i               (rx_eidle),
    .cfg_gen3_en_i                (cfg_gen3),
    .tx_os_done_i                 (tx_done),
    .tx_os_type_o                 (tx_os_type),
    .lane_active_o                (lane_active),
    .en8b10b_o                    (en8),
    .en128b130b_o                 (en128),
    .link_up_o                    (link_up),
    .mac_tx_enable_o              (mac_en),
    .state_o                      (state)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // expected architectural state
  int         exp_st;
  logic [3:0] exp_lanes;
  logic       exp_gen3;

  bit tx_pat  [1:1024];
  bit rx_pat  [1:1024];
  bit nz_pat  [1:1024];
  bit cap_pat [1:1024];
  bit idle_pat[1:64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    logic [1:0] os;
    logic       g3;
    os = (exp_st == 2) ? 2'd1 : (exp_st == 3) ? 2'd2 : 2'd0;
    g3 = exp_gen3 && (exp_st == 4);
    chk({tag, ".state"},   32'(state),       32'(exp_st));
    chk({tag, ".os_type"}, 32'(tx_os_type),  32'(os));
    chk({tag, ".lanes"},   32'(lane_active), 32'(exp_lanes));
    chk({tag, ".link_up"}, 32'(link_up),     32'(exp_st == 4));
    chk({tag, ".mac_en"},  32'(mac_en),      32'(exp_st == 4));
    chk({tag, ".en128"},   32'(en128),       32'(g3));
    chk({tag, ".en8"},     32'(en8),         32'(!g3));
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_pulses();
    tx_done = 1'b0;
    rx_ts1  = 1'b0;
    rx_ts2  = 1'b0;
  endtask

  // 16 quiet cycles with junk on the inputs, then the detect sample cycle
  task automatic run_detect(input logic [3:0] ld);
    for (int c = 1; c <= 16; c++) begin
      load_det = 4'($urandom);
      tx_done  = 1'($urandom);
      rx_ts1   = 1'($urandom);
      rx_ts2   = 1'($urandom);
      tick();
      exp_st = (c == 16) ? 1 : 0;
      chk_outs("detect");
    end
    clear_pulses();
    load_det = ld;
    tick();
    exp_st    = (ld != 4'd0) ? 2 : 0;
    exp_lanes = ld;
    chk_outs("detect_sample");
    load_det = 4'($urandom);
  endtask

  task automatic fill_zero();
    for (int c = 1; c <= 1024; c++) begin
      tx_pat[c] = 1'b0; rx_pat[c] = 1'b0; nz_pat[c] = 1'b0; cap_pat[c] = 1'b0;
    end
  endtask

  task automatic fill_random(input int p_tx, input int p_rx, input int p_nz);
    for (int c = 1; c <= 1024; c++) begin
      tx_pat[c]  = ($urandom_range(0, 99) < p_tx);
      rx_pat[c]  = ($urandom_range(0, 99) < p_rx);
      nz_pat[c]  = ($urandom_range(0, 99) < p_nz);
      cap_pat[c] = 1'($urandom_range(0, 1));
    end
  endtask

  // Outcome of a polling state from its pulse pattern: leave in cycle c when
  // the pulses of cycles 1..c-1 meet both minimums (counts past the minimum
  // do not matter), otherwise time out in cycle 1024.
  task automatic run_poll(input int code);
    int tx_n, rx_n, ex, dst;
    bit cap;
    tx_n = 0; rx_n = 0; ex = 0; dst = 0; cap = 1'b0;
    for (int c = 1; c <= 1024; c++) begin
      if (tx_n >= 16 && rx_n >= 8) begin
        ex = c; dst = code + 1;
        break;
      end
      if (c == 1024) begin
        ex = c; dst = 0;
        break;
      end
      tx_n += int'(tx_pat[c]);
      rx_n += int'(rx_pat[c]);
      if (rx_pat[c]) cap = cap_pat[c];
    end
    for (int c = 1; c <= ex; c++) begin
      clear_pulses();
      tx_done     = tx_pat[c];
      rx_gen3_cap = cap_pat[c];
      if (code == 2) begin
        // either TS type counts in POLLING_ACTIVE
        if (rx_pat[c]) begin
          if (nz_pat[c]) rx_ts2 = 1'b1;
          else           rx_ts1 = 1'b1;
        end
      end else begin
        rx_ts1 = nz_pat[c];
        if (c < ex) rx_ts2 = rx_pat[c];
      end
      tick();
      exp_st = (c < ex) ? code : dst;
      if (c == ex && dst == 4) exp_gen3 = cap & cfg_gen3;
      chk_outs((code == 2) ? "poll_active" : "poll_config");
    end
    clear_pulses();
  endtask

  // L0 drops after a run of 4 consecutive idle cycles
  task automatic run_idle(input int len);
    int run;
    run = 0;
    for (int c = 1; c <= len; c++) begin
      rx_eidle = idle_pat[c];
      tx_done  = 1'($urandom);
      rx_ts1   = 1'($urandom);
      rx_ts2   = 1'($urandom);
      tick();
      run = idle_pat[c] ? run + 1 : 0;
      if (run == 4) begin
        exp_st   = 0;
        exp_gen3 = 1'b0;
      end
      chk_outs("l0_idle");
      if (run == 4) break;
    end
    clear_pulses();
    rx_eidle = 1'b0;
  endtask

  task automatic idle_directed();
    for (int c = 1; c <= 64; c++) idle_pat[c] = 1'b0;
    idle_pat[1] = 1'b1; idle_pat[2] = 1'b1; idle_pat[3] = 1'b1;
    for (int c = 5; c <= 8; c++) idle_pat[c] = 1'b1;
    run_idle(8);
  endtask

  task automatic idle_random();
    for (int c = 1; c <= 64; c++) idle_pat[c] = ($urandom_range(0, 99) < 55);
    for (int c = 61; c <= 64; c++) idle_pat[c] = 1'b1;
    run_idle(64);
  endtask

  initial begin
    rst_i = 1'b1;
    load_det = 4'd0; rx_eidle = 1'b0; cfg_gen3 = 1'b0; rx_gen3_cap = 1'b0;
    clear_pulses();
    exp_st = 0; exp_lanes = 4'd0; exp_gen3 = 1'b0;

    // reset values, then detect cycling with no receivers
    tick();
    chk_outs("reset_hold");
    tick();
    rst_i = 1'b0;
    chk_outs("reset_release");
    run_detect(4'b0000);
    run_detect(4'b0000);

    // lane latch straight out of reset
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_lanes = 4'd0;
    chk_outs("reset2");
    run_detect(4'b0101);

    // Gen1 training: partner not gen3 capable
    fill_random(40, 30, 50);
    run_poll(2);
    fill_random(40, 30, 50);
    for (int c = 1; c <= 1024; c++) cap_pat[c] = 1'b0;
    cfg_gen3 = 1'b1;
    run_poll(3);
    idle_random();

    // Gen3 training and link down on a 4-cycle idle run
    run_detect(4'b1111);
    fill_random(40, 30, 50);
    run_poll(2);
    fill_random(40, 30, 50);
    for (int c = 1; c <= 1024; c++) cap_pat[c] = 1'b1;
    cfg_gen3 = 1'b1;
    run_poll(3);
    chk("gen3_in_l0", 32'(en128), 32'(exp_st == 4));
    idle_directed();

    // randomized training passes
    for (int i = 0; i < 3; i++) begin
      run_detect(4'($urandom_range(1, 15)));
      cfg_gen3 = 1'($urandom);
      fill_random(35, 25, 50);
      run_poll(2);
      fill_random(35, 25, 50);
      run_poll(3);
      idle_random();
    end

    // timeout with rx satisfied and no tx
    run_detect(4'b0011);
    fill_zero();
    for (int c = 1; c <= 8; c++) rx_pat[c] = 1'b1;
    run_poll(2);

    // 16th tx on cycle 1023: completion beats the timeout
    run_detect(4'b0011);
    fill_zero();
    for (int c = 1; c <= 8; c++) rx_pat[c] = 1'b1;
    for (int c = 1008; c <= 1023; c++) tx_pat[c] = 1'b1;
    run_poll(2);

    // POLLING_CONFIG: 16th tx lands too late, TS1 noise ignored -> timeout
    fill_zero();
    for (int c = 1; c <= 8; c++) rx_pat[c] = 1'b1;
    for (int c = 1009; c <= 1024; c++) tx_pat[c] = 1'b1;
    for (int c = 1; c <= 1024; c++) nz_pat[c] = 1'b1;
    run_poll(3);

    // asynchronous reset in L0
    run_detect(4'b1111);
    fill_random(40, 30, 50);
    run_poll(2);
    fill_random(40, 30, 50);
    for (int c = 1; c <= 1024; c++) cap_pat[c] = 1'b1;
    cfg_gen3 = 1'b1;
    run_poll(3);
    chk("pre_async_l0", 32'(state), 32'(exp_st));
    #1;
    rst_i = 1'b1;
    #1;
    exp_st = 0; exp_lanes = 4'd0; exp_gen3 = 1'b0;
    chk_outs("async_rst");
    rst_i = 1'b0;
    run_detect(4'b0101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
